// File: rtl/k503_line_scan_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | k503_line_scan_if : attribute-read bus and fetch handshake bundle  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface k503_line_scan_if #(
  parameter int VCNT_W = 8,
  parameter int ROW_W  = 4,
  parameter int IDX_W  = 5
) ();
  logic              ATTR_RD;
  logic [IDX_W-1:0]  ATTR_IDX;
  logic [VCNT_W-1:0] ATTR_Y;
  logic [1:0]        ATTR_FLIP;
  logic              FETCH_VALID;
  logic              FETCH_READY;
  logic [ROW_W-1:0]  FETCH_ROW;
  logic              FETCH_HFLIP;
  logic [IDX_W-1:0]  FETCH_SLOT;

  modport master (
    output ATTR_RD, ATTR_IDX, FETCH_VALID, FETCH_ROW, FETCH_HFLIP, FETCH_SLOT,
    input  ATTR_Y, ATTR_FLIP, FETCH_READY
  );

  modport slave (
    input  ATTR_RD, ATTR_IDX, FETCH_VALID, FETCH_ROW, FETCH_HFLIP, FETCH_SLOT,
    output ATTR_Y, ATTR_FLIP, FETCH_READY
  );
endinterface
`default_nettype wire

// File: rtl/k503_line_scan.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | k503_line_scan : per-scanline sprite selector with fetch handshake |
// | Option macro K503_SCAN_REVERSE_EN scans slots high-to-low. Rev 1.0 |
// +--------------------------------------------------------------------+
module k503_line_scan #(
  parameter int VCNT_W       = 8,
  parameter int ROW_W        = 4,
  parameter int SLOTS        = 24,
  parameter int MAX_PER_LINE = 8,
  parameter int IDX_W        = 5
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              CEN,
  input  logic              LINE_START,
  input  logic [VCNT_W-1:0] VCNT,
  k503_line_scan_if.master  bus,
  output logic              BUSY,
  output logic              OVF,
  output logic [IDX_W:0]    HITS
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_EVAL = 3'd2,
    S_EMIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

`ifdef K503_SCAN_REVERSE_EN
  localparam logic [IDX_W-1:0] c_SLOT_FIRST = IDX_W'(SLOTS - 1);
  localparam logic [IDX_W-1:0] c_SLOT_LAST  = IDX_W'(0);
`else
  localparam logic [IDX_W-1:0] c_SLOT_FIRST = IDX_W'(0);
  localparam logic [IDX_W-1:0] c_SLOT_LAST  = IDX_W'(SLOTS - 1);
`endif
  localparam logic [IDX_W:0] c_MAX_HITS = (IDX_W + 1)'(MAX_PER_LINE);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   slot_q, slot_d;
  logic [IDX_W:0]     hits_q, hits_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               rd_q, rd_d;
  logic               fv_q, fv_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               hflip_q, hflip_d;
  logic [IDX_W-1:0]   fslot_q, fslot_d;

  logic [VCNT_W-1:0]  w_sum;
  logic               w_hit;
  logic [IDX_W-1:0]   w_slot_next;
  logic               w_advance;

  assign w_sum = bus.ATTR_Y + VCNT;
  // The sprite covers this line when the upper sum bits have all reached ones.
  assign w_hit = &w_sum[VCNT_W-1:ROW_W];

`ifdef K503_SCAN_REVERSE_EN
  assign w_slot_next = slot_q - IDX_W'(1);
`else
  assign w_slot_next = slot_q + IDX_W'(1);
`endif

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    hits_d    = hits_q;
    ovf_d     = ovf_q;
    busy_d    = busy_q;
    rd_d      = rd_q;
    fv_d      = fv_q;
    row_d     = row_q;
    hflip_d   = hflip_q;
    fslot_d   = fslot_q;
    w_advance = 1'b0;

    if (CEN) begin
      // A new line always restarts, even over a fetch being accepted now.
      if (LINE_START) begin
        state_d = S_REQ;
        slot_d  = c_SLOT_FIRST;
        hits_d  = '0;
        ovf_d   = 1'b0;
        busy_d  = 1'b1;
        rd_d    = 1'b1;
        fv_d    = 1'b0;
      end else begin
        case (state_q)
          S_REQ: begin
            state_d = S_EVAL;
            rd_d    = 1'b0;
          end
          S_EVAL: begin
            if (w_hit) begin
              if (hits_q == c_MAX_HITS) begin
                ovf_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = S_DONE;
              end else begin
                row_d   = w_sum[ROW_W-1:0] ^ {ROW_W{bus.ATTR_FLIP[1]}};
                hflip_d = bus.ATTR_FLIP[0];
                fslot_d = slot_q;
                fv_d    = 1'b1;
                state_d = S_EMIT;
              end
            end else begin
              w_advance = 1'b1;
            end
          end
          S_EMIT: begin
            if (bus.FETCH_READY) begin
              fv_d      = 1'b0;
              hits_d    = hits_q + (IDX_W + 1)'(1);
              w_advance = 1'b1;
            end
          end
          default: ;
        endcase

        if (w_advance) begin
          if (slot_q == c_SLOT_LAST) begin
            busy_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            slot_d  = w_slot_next;
            rd_d    = 1'b1;
            state_d = S_REQ;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= S_IDLE;
      slot_q  <= '0;
      hits_q  <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      rd_q    <= 1'b0;
      fv_q    <= 1'b0;
      row_q   <= '0;
      hflip_q <= 1'b0;
      fslot_q <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      hits_q  <= hits_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      rd_q    <= rd_d;
      fv_q    <= fv_d;
      row_q   <= row_d;
      hflip_q <= hflip_d;
      fslot_q <= fslot_d;
    end
  end

  assign bus.ATTR_RD     = rd_q;
  assign bus.ATTR_IDX    = slot_q;
  assign bus.FETCH_VALID = fv_q;
  assign bus.FETCH_ROW   = row_q;
  assign bus.FETCH_HFLIP = hflip_q;
  assign bus.FETCH_SLOT  = fslot_q;
  assign BUSY            = busy_q;
  assign OVF             = ovf_q;
  assign HITS            = hits_q;

endmodule
`default_nettype wire

// File: tb/tb_k503_line_scan.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_k503_line_scan : directed self-checking bench for k503_line_scan|
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_k503_line_scan;

`ifdef K503_SCAN_REVERSE_EN
  localparam int c_FIRST    = 23;
  localparam int c_LAST     = 0;
  localparam int c_OVF_F0   = 23;
  localparam int c_OVF_F7   = 16;
  localparam int c_OVF_LRD  = 15;
`else
  localparam int c_FIRST    = 0;
  localparam int c_LAST     = 23;
  localparam int c_OVF_F0   = 0;
  localparam int c_OVF_F7   = 7;
  localparam int c_OVF_LRD  = 8;
`endif

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       cen = 1'b1;
  logic       line_start = 1'b0;
  logic [7:0] vcnt = 8'h00;
  logic       ready = 1'b0;
  logic       busy, ovf;
  logic [5:0] hits;

  logic [7:0] y_mem    [32];
  logic [1:0] flip_mem [32];

  int errors = 0;
  int checks = 0;

  int       acc_cnt = 0;
  int       rd_cnt  = 0;
  int       last_rd = 0;
  int       acc_slot [1024];
  int       acc_row  [1024];
  int       acc_hf   [1024];

  k503_line_scan_if #(.VCNT_W(8), .ROW_W(4), .IDX_W(5)) ifc ();

  assign ifc.ATTR_Y      = y_mem[ifc.ATTR_IDX];
  assign ifc.ATTR_FLIP   = flip_mem[ifc.ATTR_IDX];
  assign ifc.FETCH_READY = ready;

  k503_line_scan #(
    .VCNT_W(8), .ROW_W(4), .SLOTS(24), .MAX_PER_LINE(8), .IDX_W(5)
  ) dut (
    .CLK        (clk),
    .nRESET     (nrst),
    .CEN        (cen),
    .LINE_START (line_start),
    .VCNT       (vcnt),
    .bus        (ifc),
    .BUSY       (busy),
    .OVF        (ovf),
    .HITS       (hits)
  );

  always #5 clk = ~clk;

  // Log of accepted fetches and attribute reads seen on active edges.
  always @(posedge clk) begin
    if (nrst && cen && ifc.FETCH_VALID && ready && !line_start) begin
      acc_slot[acc_cnt % 1024] <= int'(ifc.FETCH_SLOT);
      acc_row[acc_cnt % 1024]  <= int'(ifc.FETCH_ROW);
      acc_hf[acc_cnt % 1024]   <= int'(ifc.FETCH_HFLIP);
      acc_cnt <= acc_cnt + 1;
    end
    if (nrst && cen && ifc.ATTR_RD) begin
      rd_cnt  <= rd_cnt + 1;
      last_rd <= int'(ifc.ATTR_IDX);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_line();
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, output int n);
    n = 0;
    while (busy && n < 1000) begin
      tick();
      n++;
    end
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!ifc.FETCH_VALID && n < 500) begin
      tick();
      n++;
    end
    check({tag, "_valid_seen"}, 32'(ifc.FETCH_VALID), 32'd1);
  endtask

  task automatic fill(input logic [7:0] y_all);
    for (int i = 0; i < 32; i++) begin
      y_mem[i]    = y_all;
      flip_mem[i] = 2'b00;
    end
  endtask

  // One scan with a single candidate in slot 3; checks row/hflip of the result.
  task automatic one_hit(input string tag, input logic [7:0] y3, input logic [1:0] f3,
                         input int exp_n, input int exp_row, input int exp_hf);
    int base;
    int n;
    y_mem[3]    = y3;
    flip_mem[3] = f3;
    base = acc_cnt;
    start_line();
    wait_idle(tag, n);
    check({tag, "_nfetch"}, 32'(acc_cnt - base), 32'(exp_n));
    check({tag, "_hits"}, 32'(hits), 32'(exp_n));
    if (exp_n == 1) begin
      check({tag, "_slot"}, 32'(acc_slot[base]), 32'd3);
      check({tag, "_row"}, 32'(acc_row[base]), 32'(exp_row));
      check({tag, "_hflip"}, 32'(acc_hf[base]), 32'(exp_hf));
    end
  endtask

  initial begin
    int base;
    int rbase;
    int n;

    fill(8'h00);
    tick();
    tick();
    check("reset_outputs",
          {20'd0, ifc.ATTR_RD, ifc.ATTR_IDX, ifc.FETCH_VALID, busy, ovf, hits[2:0]},
          32'd0);
    check("reset_fetch", {20'd0, ifc.FETCH_ROW, ifc.FETCH_HFLIP, ifc.FETCH_SLOT, hits[5:3]}, 32'd0);
    nrst = 1'b1;
    tick();

    // Single hit: 0x20 + 0xDF = 0xFF, row 15
    vcnt  = 8'h20;
    ready = 1'b1;
    fill(8'h00);
    y_mem[3] = 8'hDF;
    base = acc_cnt;
    start_line();
    check("single_busy_on", 32'(busy), 32'd1);
    check("single_first_idx", 32'(ifc.ATTR_IDX), 32'(c_FIRST));
    wait_idle("single", n);
    check("single_cycles", 32'(n), 32'd49);
    check("single_nfetch", 32'(acc_cnt - base), 32'd1);
    check("single_slot", 32'(acc_slot[base]), 32'd3);
    check("single_row", 32'(acc_row[base]), 32'hF);
    check("single_hits", 32'(hits), 32'd1);
    check("single_ovf", 32'(ovf), 32'd0);
    check("single_last_rd", 32'(last_rd), 32'(c_LAST));

    one_hit("vflip", 8'hDF, 2'b10, 1, 0, 0);
    one_hit("hflip", 8'hDF, 2'b01, 1, 15, 1);

    // Wrap and boundaries; filler 0x80 gives sum 0x70, never a hit
    vcnt = 8'hF0;
    fill(8'h80);
    one_hit("wrap_f5", 8'h05, 2'b00, 1, 5, 0);
    one_hit("wrap_ff", 8'h0F, 2'b00, 1, 15, 0);
    one_hit("wrap_00", 8'h10, 2'b00, 0, 0, 0);

    // Overflow: every slot hits
    vcnt = 8'h20;
    fill(8'hDF);
    base  = acc_cnt;
    rbase = rd_cnt;
    start_line();
    wait_idle("ovf", n);
    check("ovf_cycles", 32'(n), 32'd26);
    check("ovf_nfetch", 32'(acc_cnt - base), 32'd8);
    check("ovf_first_slot", 32'(acc_slot[base]), 32'(c_OVF_F0));
    check("ovf_last_slot", 32'(acc_slot[base + 7]), 32'(c_OVF_F7));
    check("ovf_flag", 32'(ovf), 32'd1);
    check("ovf_hits", 32'(hits), 32'd8);
    check("ovf_reads", 32'(rd_cnt - rbase), 32'd9);
    check("ovf_last_rd", 32'(last_rd), 32'(c_OVF_LRD));

    // Backpressure then abort with a coincident accept
    fill(8'h00);
    y_mem[3] = 8'hDF;
    ready = 1'b0;
    start_line();
    check("abort_ovf_cleared", 32'(ovf), 32'd0);
    wait_valid("bp");
    base  = acc_cnt;
    rbase = rd_cnt;
    repeat (10) tick();
    check("bp_valid_held", 32'(ifc.FETCH_VALID), 32'd1);
    check("bp_slot", 32'(ifc.FETCH_SLOT), 32'd3);
    check("bp_row", 32'(ifc.FETCH_ROW), 32'hF);
    check("bp_no_read", 32'(rd_cnt - rbase), 32'd0);
    check("bp_rd_low", 32'(ifc.ATTR_RD), 32'd0);
    line_start = 1'b1;
    ready      = 1'b1;
    tick();
    line_start = 1'b0;
    check("abort_hits", 32'(hits), 32'd0);
    check("abort_no_accept", 32'(acc_cnt - base), 32'd0);
    check("abort_valid", 32'(ifc.FETCH_VALID), 32'd0);
    check("abort_req", {30'd0, ifc.ATTR_RD, busy}, 32'd3);
    check("abort_idx", 32'(ifc.ATTR_IDX), 32'(c_FIRST));

    // CEN low freezes the scan, LINE_START included
    cen = 1'b0;
    repeat (5) begin
      line_start = ~line_start;
      tick();
    end
    line_start = 1'b0;
    check("cen_hold_req", {30'd0, ifc.ATTR_RD, busy}, 32'd3);
    check("cen_hold_idx", 32'(ifc.ATTR_IDX), 32'(c_FIRST));
    check("cen_hold_hits", 32'(hits), 32'd0);
    cen = 1'b1;
    base = acc_cnt;
    wait_idle("cen_resume", n);
    check("cen_resume_cycles", 32'(n), 32'd49);
    check("cen_resume_hits", 32'(hits), 32'd1);
    check("cen_resume_slot", 32'(acc_slot[base]), 32'd3);

    // Asynchronous reset while a fetch is pending
    ready = 1'b0;
    start_line();
    wait_valid("rst");
    nrst = 1'b0;
    #1;
    check("rst_async_outputs",
          {20'd0, ifc.ATTR_RD, ifc.ATTR_IDX, ifc.FETCH_VALID, busy, ovf, hits[2:0]},
          32'd0);
    check("rst_async_fetch", {20'd0, ifc.FETCH_ROW, ifc.FETCH_HFLIP, ifc.FETCH_SLOT, hits[5:3]}, 32'd0);
    #1;
    nrst = 1'b1;
    tick();
    tick();
    check("rst_stays_idle", {30'd0, ifc.FETCH_VALID, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/k503_line_scan.md
Name: k503_line_scan

Overview:
- Synchronous, parametrised successor to the 503-style sprite selector.
- Once per scanline, walks the sprite attribute slots and sums each sprite's Y with VCNT to pick sprites visible on that line.
- Emits one fetch request per hit (row within sprite, flip bits, slot index) over a valid/ready handshake to the sprite ROM/line-buffer loader.
- Enforces a per-line sprite limit with an overflow flag; runs on the core's master clock gated by a pixel clock enable.

Parameters:
- VCNT_W, 8: width of VCNT and attribute Y.
- ROW_W, 4: row-within-sprite bits; sprite height = 2**ROW_W; must be less than VCNT_W.
- SLOTS, 24: attribute slots scanned per line; range 2..256.
- MAX_PER_LINE, 8: hits accepted per line before overflow; range 1..SLOTS.
- IDX_W, 5: slot index width; 2**IDX_W >= SLOTS.

Ports:
- CLK  in  1  master clock
- nRESET  in  1  asynchronous active-low reset
- CEN  in  1  clock enable; all state advances only when CEN=1
- LINE_START  in  1  start-of-scan pulse, sampled on CEN
- VCNT  in  VCNT_W  vertical counter, held stable during the scan
- ATTR_RD  out  1  attribute read strobe
- ATTR_IDX  out  IDX_W  slot being read
- ATTR_Y  in  VCNT_W  slot Y; valid one CEN cycle after ATTR_RD
- ATTR_FLIP  in  2  {vflip, hflip}; same timing as ATTR_Y
- FETCH_VALID  out  1  hit available
- FETCH_READY  in  1  consumer accepts the hit
- FETCH_ROW  out  ROW_W  row address, vflip applied
- FETCH_HFLIP  out  1  hflip of the hit
- FETCH_SLOT  out  IDX_W  slot index of the hit
- BUSY  out  1  scan in progress
- OVF  out  1  line overflow, sticky until next LINE_START
- HITS  out  IDX_W+1  hits accepted this line

Behaviour:
- Reset (nRESET=0, asynchronous): state IDLE; every output 0.
- All outputs are registered. All transitions are qualified by CEN; with CEN=0, all state holds.
- States:
  - IDLE/DONE: BUSY=0. LINE_START → REQ, slot=0, HITS=0, OVF=0.
  - REQ: ATTR_RD=1, ATTR_IDX=slot, BUSY=1. Next CEN → EVAL.
  - EVAL: sum = ATTR_Y + VCNT modulo 2**VCNT_W. Hit when sum[VCNT_W-1:ROW_W] is all ones.
    - Row = sum[ROW_W-1:0] XOR {ROW_W{vflip}}.
    - Hit and HITS<MAX_PER_LINE: latch FETCH_* outputs, go to EMIT.
    - Hit and HITS==MAX_PER_LINE: OVF=1, go to DONE.
    - No hit: advance.
  - EMIT: FETCH_VALID=1; FETCH_* outputs stay stable until accepted. Acceptance is FETCH_VALID & FETCH_READY on a CEN cycle; then FETCH_VALID=0, HITS+1, advance.
  - Advance: last slot (SLOTS-1) → DONE; otherwise slot+1 → REQ.
- Throughput: 2 CEN cycles per missed slot; 3+ per hit. A full scan without hits takes 2*SLOTS CEN cycles.
- LINE_START in any state other than IDLE aborts the scan and restarts at slot 0, with HITS and OVF cleared. If a pending fetch is accepted in the same cycle, the restart wins: HITS is cleared, not incremented.
- FETCH_READY is ignored outside EMIT.
- VCNT is sampled in EVAL; a VCNT change mid-scan affects only later slots.
- nRESET mid-scan returns immediately to IDLE; no partial fetch is presented.

Optional Feature:
- Macro: K503_SCAN_REVERSE_EN.
- Defined: the scan starts at slot SLOTS-1 and decrements; the last slot is 0. Under overflow, low-index sprites are dropped instead of high-index ones.
- Undefined: the scan is ascending as described above.
- Ports and timing are identical in both builds.

Test Plan:
- Single hit, default parameters: VCNT=0x20, slot 3 Y=0xDF, all other slots Y=0x00, FETCH_READY=1 → exactly one FETCH_VALID pulse with FETCH_SLOT=3, FETCH_ROW=0xF, HITS=1, OVF=0; BUSY falls after slot 23.
- Vflip: same setup with ATTR_FLIP=2'b10 → FETCH_ROW=0x0, FETCH_HFLIP=0. With ATTR_FLIP=2'b01 → FETCH_ROW=0xF, FETCH_HFLIP=1.
- Wrap and boundaries: VCNT=0xF0, Y=0x05 → sum 0xF5, hit with row 5. Y=0x0F → sum 0xFF, hit with row 15. Y=0x10 → sum wraps to 0x00, no hit.
- Overflow: all 24 slots hit, MAX_PER_LINE=8 → 8 fetches for slots 0..7, then OVF=1, HITS=8, BUSY=0 without reading beyond slot 8 (slots 0..23 with SCAN_REVERSE_EN: fetches for 23..16).
- Backpressure and abort: hold FETCH_READY=0 for 10 CEN cycles → FETCH_* outputs stable, no ATTR_RD. Then assert LINE_START together with FETCH_READY=1 → HITS=0, ATTR_IDX=0 on the next REQ.
- Reset and CEN: drop nRESET mid-EMIT → all outputs 0 immediately, without waiting for a clock edge. With CEN=0 for 5 clocks during a scan → no state change.
